// File: rtl/vc_output_scheduler.sv
// Round-robin scheduler draining VC FIFOs into one shared output FIFO,
// with bounded bursts per grant and full/almost-full throttling.
//
// Ports:
//   clk             system clock, all state on rising edge
//   rst             asynchronous active-low reset
//   enb             block enable; low forces IDLE
//   vc_empty        per-VC FIFO empty flags
//   vc_data         per-VC FWFT head words, VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   continuar       per-VC permission from flow control (1 = may serve)
//   out_full        output FIFO full
//   out_almost_full output FIFO has at most one free slot
//   vc_pop          combinational one-hot (or zero) pop to the VC FIFOs
//   out_push        registered push to the output FIFO
//   out_data        registered word for the output FIFO
//   grant           registered one-hot of the VC currently held
//   busy            registered, high while bursting
module vc_output_scheduler #(
    parameter int VC_COUNT   = 4,
    parameter int DATA_WIDTH = 6,
    parameter int BURST_MAX  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enb,
    input  logic [VC_COUNT-1:0]            vc_empty,
    input  logic [VC_COUNT*DATA_WIDTH-1:0] vc_data,
    input  logic [VC_COUNT-1:0]            continuar,
    input  logic                           out_full,
    input  logic                           out_almost_full,
    output logic [VC_COUNT-1:0]            vc_pop,
    output logic                           out_push,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [VC_COUNT-1:0]            grant,
    output logic                           busy
);

    localparam int PW = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [PW-1:0]       hold_q, hold_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VC_COUNT-1:0] grant_q, grant_d;
    logic                busy_q, busy_d;

    logic [VC_COUNT-1:0] eligible;
    logic                space;
    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       sel_idx;
    logic [VC_COUNT-1:0] pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        int n;
        n = (int'(idx) + 1) % VC_COUNT;
        return PW'(n);
    endfunction

    assign eligible = ~vc_empty & continuar;

    // A push registered last cycle still occupies the last free slot.
    assign space = ~out_full & ~(out_almost_full & out_push);

    // First eligible VC starting at rr_q, wrapping modulo VC_COUNT.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < VC_COUNT; k++) begin
            idx = (int'(rr_q) + k) % VC_COUNT;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        pop     = '0;
        if (!enb) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARB;
                end
                ARB: begin
                    if (win_found && space) begin
                        pop[win_idx]     = 1'b1;
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        hold_d           = win_idx;
                        cnt_d            = CNT_ONE;
                        if (BURST_MAX > 1) begin
                            state_d = BURST;
                            busy_d  = 1'b1;
                        end else begin
                            rr_d = next_ptr(win_idx);
                        end
                    end else begin
                        grant_d = '0;
                    end
                end
                BURST: begin
                    if (eligible[hold_q] && cnt_q < CNT_MAX) begin
                        // Without space this is a stall: hold everything.
                        if (space) begin
                            pop[hold_q] = 1'b1;
                            cnt_d       = cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Release costs one bubble; served VC drops to
                        // lowest priority.
                        rr_d    = next_ptr(hold_q);
                        grant_d = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The popped VC is either the arbitration winner or the held VC.
    assign sel_idx = (state_q == ARB) ? win_idx : hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_push <= 1'b0;
            out_data <= '0;
        end else if (|pop) begin
            out_push <= 1'b1;
            out_data <= vc_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            out_push <= 1'b0;
        end
    end

    assign vc_pop = pop;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule
